// File: rtl/score_history_writer.sv
// Logs each game's final score into the shared 16x8 memory: address BEST_ADDR holds the best score, the rest form a circular history.
// Optional build macro SCORE_BCD_EN: write data as two BCD digits instead of zero-extended binary.
module score_history_writer #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SCORE_WIDTH = 6,
    parameter int unsigned BEST_ADDR   = 0
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Game_Over,
    input  logic [SCORE_WIDTH-1:0] i_Score,
    output logic                   o_W_En,
    output logic [ADDR_WIDTH-1:0]  o_W_Addr,
    output logic [DATA_WIDTH-1:0]  o_W_Data,
    output logic [SCORE_WIDTH-1:0] o_Best_Score,
    output logic [3:0]             o_Entries,
    output logic                   o_Busy,
    output logic                   o_Overflow
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_LOG,
        S_BEST
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic                   prev_q;
    logic                   pend_q, pend_d;
    logic [SCORE_WIDTH-1:0] pend_score_q, pend_score_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0]  w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
    logic [SCORE_WIDTH-1:0] best_q, best_d;
    logic [3:0]             entries_q, entries_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic                   trig;

    function automatic logic [DATA_WIDTH-1:0] fmt(input logic [SCORE_WIDTH-1:0] s);
`ifdef SCORE_BCD_EN
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(s / SCORE_WIDTH'(10));
        ones = 4'(s % SCORE_WIDTH'(10));
        fmt  = DATA_WIDTH'({tens, ones});
`else
        fmt  = DATA_WIDTH'(s);
`endif
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        pend_d       = pend_q;
        pend_score_d = pend_score_q;
        score_d      = score_q;
        w_en_d       = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        best_d       = best_q;
        entries_d    = entries_q;
        ovf_d        = ovf_q;
        trig         = i_Game_Over & ~prev_q;

        // Triggers arriving while busy go to the one-deep slot; a second one is lost.
        if (trig && state_q != S_IDLE) begin
            if (pend_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_d       = 1'b1;
                pend_score_d = i_Score;
            end
        end

        case (state_q)
            S_CLEAR: begin
                w_en_d   = 1'b1;
                w_addr_d = cnt_q;
                w_data_d = '0;
                cnt_d    = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (pend_q) begin
                    score_d = pend_score_q;
                    pend_d  = trig;
                    if (trig) pend_score_d = i_Score;
                    state_d = S_LOG;
                end else if (trig) begin
                    score_d = i_Score;
                    state_d = S_LOG;
                end
            end
            S_LOG: begin
                w_en_d   = 1'b1;
                w_addr_d = ptr_q;
                w_data_d = fmt(score_q);
                ptr_d    = (ptr_q == '1) ? ADDR_WIDTH'(1) : ptr_q + ADDR_WIDTH'(1);
                if (entries_q != 4'd15) entries_d = entries_q + 4'd1;
                state_d  = (score_q > best_q) ? S_BEST : S_IDLE;
            end
            S_BEST: begin
                w_en_d   = 1'b1;
                w_addr_d = ADDR_WIDTH'(BEST_ADDR);
                w_data_d = fmt(score_q);
                best_d   = score_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_CLEAR;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            ptr_q        <= ADDR_WIDTH'(1);
            prev_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_score_q <= '0;
            score_q      <= '0;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            best_q       <= '0;
            entries_q    <= '0;
            busy_q       <= 1'b1;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            prev_q       <= i_Game_Over;
            pend_q       <= pend_d;
            pend_score_q <= pend_score_d;
            score_q      <= score_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            best_q       <= best_d;
            entries_q    <= entries_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
        end
    end

    assign o_W_En       = w_en_q;
    assign o_W_Addr     = w_addr_q;
    assign o_W_Data     = w_data_q;
    assign o_Best_Score = best_q;
    assign o_Entries    = entries_q;
    assign o_Busy       = busy_q;
    assign o_Overflow   = ovf_q;

endmodule

// File: tb/tb_score_history_writer.sv
// Bench for score_history_writer: transaction-level model of expected memory writes, best score and entry count.
module tb_score_history_writer;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic [5:0] score;
    logic       o_W_En;
    logic [3:0] o_W_Addr;
    logic [7:0] o_W_Data;
    logic [5:0] o_Best_Score;
    logic [3:0] o_Entries;
    logic       o_Busy;
    logic       o_Overflow;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    logic [11:0] mon_q[$];
    logic [11:0] exp_q[$];
    logic [3:0]  m_ptr;
    int unsigned m_best;
    int unsigned m_entries;

    score_history_writer #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .SCORE_WIDTH(6),
        .BEST_ADDR  (0)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Game_Over (go),
        .i_Score     (score),
        .o_W_En      (o_W_En),
        .o_W_Addr    (o_W_Addr),
        .o_W_Data    (o_W_Data),
        .o_Best_Score(o_Best_Score),
        .o_Entries   (o_Entries),
        .o_Busy      (o_Busy),
        .o_Overflow  (o_Overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n && o_W_En) mon_q.push_back({o_W_Addr, o_W_Data});
    end

    function automatic logic [7:0] tb_fmt(input int unsigned s);
`ifdef SCORE_BCD_EN
        return 8'((s / 10) * 16 + (s % 10));
`else
        return 8'(s);
`endif
    endfunction

    // Reference: each game writes the next history slot, then the best slot if it beats the record.
    task automatic m_log(input int unsigned s);
        exp_q.push_back({m_ptr, tb_fmt(s)});
        m_ptr = (m_ptr == 4'd15) ? 4'd1 : m_ptr + 4'd1;
        if (m_entries < 15) m_entries++;
        if (s > m_best) begin
            exp_q.push_back({4'd0, tb_fmt(s)});
            m_best = s;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        go    = 1'b0;
        score = '0;
        repeat (2) @(negedge clk);
        m_ptr = 4'd1; m_best = 0; m_entries = 0;
        exp_q.delete();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        mon_q.delete();
    endtask

    task automatic play(input int unsigned s, input int unsigned hold);
        @(negedge clk);
        score = 6'(s);
        go    = 1'b1;
        repeat (hold) @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (!o_Busy && !o_W_En) break;
            @(negedge clk);
        end
        total_cnt++;
        if (o_Busy || o_W_En) $display("FAIL idle_timeout busy=%0b w_en=%0b required 0/0", o_Busy, o_W_En);
        else pass_cnt++;
        m_log(s);
    endtask

    task automatic test_clear();
        int unsigned cyc;
        @(negedge clk);
        rst_n = 1'b0; go = 1'b0; score = '0;
        #1;
        total_cnt++;
        if ({o_W_En, o_Busy, o_Best_Score, o_Entries, o_Overflow, o_W_Addr, o_W_Data} !== {1'b0, 1'b1, 6'd0, 4'd0, 1'b0, 4'd0, 8'd0})
            $display("FAIL reset_values en=%0b busy=%0b best=%0d ent=%0d ovf=%0b addr=%0d data=%0h required 0 1 0 0 0 0 0",
                     o_W_En, o_Busy, o_Best_Score, o_Entries, o_Overflow, o_W_Addr, o_W_Data);
        else pass_cnt++;
        @(negedge clk);
        mon_q.delete();
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!o_Busy) break;
            cyc++;
            @(negedge clk);
        end
        total_cnt++;
        if (cyc != 16) $display("FAIL clear_busy_cycles got %0d required 16", cyc);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (mon_q.size() != 16) $display("FAIL clear_write_count got %0d required 16", mon_q.size());
        else pass_cnt++;
        for (int k = 0; k < 16 && k < mon_q.size(); k++) begin
            total_cnt++;
            if (mon_q[k] !== {4'(k), 8'h00}) $display("FAIL clear_write[%0d] got %03h required %03h", k, mon_q[k], {4'(k), 8'h00});
            else pass_cnt++;
        end
        total_cnt++;
        if (o_Busy !== 1'b0 || o_Entries !== 4'd0) $display("FAIL clear_done busy=%0b ent=%0d required 0 0", o_Busy, o_Entries);
        else pass_cnt++;
        m_ptr = 4'd1; m_best = 0; m_entries = 0;
        exp_q.delete();
        mon_q.delete();
    endtask

    task automatic test_basic();
        @(negedge clk);
        score = 6'd12; go = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (o_W_En !== 1'b0 || o_Busy !== 1'b1) $display("FAIL trig_edge en=%0b busy=%0b required 0 1", o_W_En, o_Busy);
        else pass_cnt++;
        @(posedge clk); #1;
        go = 1'b0;
        total_cnt++;
        if ({o_W_En, o_W_Addr, o_W_Data} !== {1'b1, 4'd1, tb_fmt(12)})
            $display("FAIL log_write en=%0b addr=%0d data=%02h required 1 1 %02h", o_W_En, o_W_Addr, o_W_Data, tb_fmt(12));
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({o_W_En, o_W_Addr, o_W_Data, o_Best_Score, o_Entries} !== {1'b1, 4'd0, tb_fmt(12), 6'd12, 4'd1})
            $display("FAIL best_write en=%0b addr=%0d data=%02h best=%0d ent=%0d required 1 0 %02h 12 1",
                     o_W_En, o_W_Addr, o_W_Data, o_Best_Score, o_Entries, tb_fmt(12));
        else pass_cnt++;
        repeat (3) @(negedge clk);
        m_log(12);
        mon_q.delete(); exp_q.delete();
        play(7, 1);
        total_cnt++;
        if (mon_q.size() != 1 || mon_q[0] !== {4'd2, tb_fmt(7)} || o_Best_Score !== 6'd12)
            $display("FAIL lower_score writes=%0d first=%03h best=%0d required 1 %03h 12", mon_q.size(), mon_q[0], o_Best_Score, {4'd2, tb_fmt(7)});
        else pass_cnt++;
        mon_q.delete();
        play(12, 2);
        total_cnt++;
        if (mon_q.size() != 1 || mon_q[0] !== {4'd3, tb_fmt(12)} || o_Entries !== 4'd3)
            $display("FAIL equal_score writes=%0d first=%03h ent=%0d required 1 %03h 3", mon_q.size(), mon_q[0], o_Entries, {4'd3, tb_fmt(12)});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 1; s <= 16; s++) play(s, 1);
        total_cnt++;
        if (mon_q.size() != exp_q.size()) $display("FAIL wrap_count got %0d required %0d", mon_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            total_cnt++;
            if (mon_q[i] !== exp_q[i]) $display("FAIL wrap_write[%0d] got %03h required %03h", i, mon_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (mon_q.size() < 2 || mon_q[mon_q.size()-2] !== {4'd1, tb_fmt(16)})
            $display("FAIL wrap_game16 got %03h required %03h", mon_q[mon_q.size()-2], {4'd1, tb_fmt(16)});
        else pass_cnt++;
        total_cnt++;
        if (o_Entries !== 4'd15 || o_Best_Score !== 6'd16) $display("FAIL wrap_state ent=%0d best=%0d required 15 16", o_Entries, o_Best_Score);
        else pass_cnt++;
    endtask

    task automatic test_pending();
        logic seen;
        rst_n = 1'b0; go = 1'b0; score = '0;
        repeat (2) @(negedge clk);
        mon_q.delete(); exp_q.delete();
        m_ptr = 4'd1; m_best = 0; m_entries = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), 8'h00});
        repeat (3) @(negedge clk);
        score = 6'd5; go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (2) @(negedge clk);
        score = 6'd33; go = 1'b1;
        @(negedge clk); go = 1'b0; score = '0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_W_En && o_W_Addr == 4'd1 && o_W_Data == tb_fmt(5)) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!seen) $display("FAIL pending_first_log got none required addr1=%02h", tb_fmt(5));
        else pass_cnt++;
        score = 6'd9; go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (10) @(negedge clk);
        m_log(5); m_log(9);
        total_cnt++;
        if (mon_q.size() != exp_q.size()) $display("FAIL pending_count got %0d required %0d", mon_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 16; i < exp_q.size() && i < mon_q.size(); i++) begin
            total_cnt++;
            if (mon_q[i] !== exp_q[i]) $display("FAIL pending_write[%0d] got %03h required %03h", i, mon_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (o_Overflow !== 1'b1 || o_Entries !== 4'd2 || o_Best_Score !== 6'd9)
            $display("FAIL pending_state ovf=%0b ent=%0d best=%0d required 1 2 9", o_Overflow, o_Entries, o_Best_Score);
        else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        play(0, 1);
        for (int g = 0; g < 24; g++) play($urandom_range(0, 63), $urandom_range(1, 3));
        total_cnt++;
        if (mon_q.size() != exp_q.size()) $display("FAIL random_count got %0d required %0d", mon_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            total_cnt++;
            if (mon_q[i] !== exp_q[i]) $display("FAIL random_write[%0d] got %03h required %03h", i, mon_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (o_Best_Score !== 6'(m_best) || o_Entries !== 4'(m_entries) || o_Overflow !== 1'b0)
            $display("FAIL random_state best=%0d ent=%0d ovf=%0b required %0d %0d 0", o_Best_Score, o_Entries, o_Overflow, m_best, m_entries);
        else pass_cnt++;
    endtask

    task automatic test_format();
        logic [7:0] exp42;
`ifdef SCORE_BCD_EN
        exp42 = 8'h42;
`else
        exp42 = 8'h2A;
`endif
        do_reset();
        play(42, 1);
        total_cnt++;
        if (mon_q.size() != 2 || mon_q[0] !== {4'd1, exp42} || mon_q[1] !== {4'd0, exp42})
            $display("FAIL format_42 n=%0d w0=%03h w1=%03h required 2 %03h %03h", mon_q.size(), mon_q[0], mon_q[1], {4'd1, exp42}, {4'd0, exp42});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        @(negedge clk);
        score = 6'd50; go = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_W_En) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!seen) $display("FAIL midreset_write_start got none required w_en=1");
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (o_W_En !== 1'b0 || o_Busy !== 1'b1 || o_Best_Score !== 6'd0)
            $display("FAIL midreset_async en=%0b busy=%0b best=%0d required 0 1 0", o_W_En, o_Busy, o_Best_Score);
        else pass_cnt++;
        go = 1'b0;
        @(negedge clk);
        mon_q.delete();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total_cnt++;
        if (mon_q.size() != 16 || mon_q[0] !== 12'h000 || mon_q[15] !== {4'd15, 8'h00})
            $display("FAIL midreset_clear n=%0d first=%03h last=%03h required 16 000 f00", mon_q.size(), mon_q[0], mon_q[15]);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; score = '0;
        m_ptr = 4'd1; m_best = 0; m_entries = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_clear();
        test_basic();
        test_wrap();
        test_pending();
        test_random();
        test_format();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
